// File: rtl/mem_ctrl.sv
// mem_ctrl - arbitrates the byte-wide RAM port between instruction fetch
// (always 4-byte refills) and the load/store buffer (1/2/4-byte accesses).
// Each request is serialised into byte accesses; read bytes are assembled
// little-endian and a one-cycle done pulse goes to the owning requester.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes every register
//   if_to_mc_*          fetch request (level, held until done)
//   mc_to_if_*          fetch done pulse / fetched word
//   lsb_to_mc_*         load/store request (level, held until done)
//   mc_to_lsb_*         load/store done pulse / zero-extended load data
//   rob_to_mc_flush     rollback: aborts reads, blocks grants
//   mem_din/dout/a/wr   byte RAM port (read data arrives one cycle late)
//   io_buffer_full      stalls writes into IO space (addr >= IO_BASE)
//
// Build option: define MC_RR_ARB_EN to replace fixed LSB priority with
// round-robin arbitration on simultaneous requests.
module mem_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(32'h00030000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  if_to_mc_enable,
    input  logic [ADDR_WIDTH-1:0] if_to_mc_pc,
    output logic                  mc_to_if_done,
    output logic [31:0]           mc_to_if_result,
    input  logic                  lsb_to_mc_enable,
    input  logic                  lsb_to_mc_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_to_mc_addr,
    input  logic [2:0]            lsb_to_mc_len,
    input  logic [31:0]           lsb_to_mc_data,
    output logic                  mc_to_lsb_done,
    output logic [31:0]           mc_to_lsb_result,
    input  logic                  rob_to_mc_flush,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSB = 1'b1;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [2:0]            len_q, len_n;
    logic [2:0]            cnt_q, cnt_n;
    logic                  owner_q, owner_n;
    logic [31:0]           wdata_q, wdata_n;
    logic [31:0]           rbuf_q, rbuf_n;

    logic [ADDR_WIDTH-1:0] mem_a_n;
    logic [7:0]            mem_dout_n;
    logic                  mem_wr_n;
    logic                  if_done_n, lsb_done_n;
    logic [31:0]           if_result_n, lsb_result_n;

    logic                  pick_lsb;
    logic [2:0]            rd_idx;
    logic [1:0]            cap_idx;
    logic [ADDR_WIDTH-1:0] wr_addr;

`ifdef MC_RR_ARB_EN
    logic rr_last_q, rr_last_n;
`endif

    always_comb begin
        state_n      = state_q;
        addr_n       = addr_q;
        len_n        = len_q;
        cnt_n        = cnt_q;
        owner_n      = owner_q;
        wdata_n      = wdata_q;
        rbuf_n       = rbuf_q;
        mem_a_n      = mem_a;
        mem_dout_n   = mem_dout;
        mem_wr_n     = mem_wr;
        if_done_n    = 1'b0;   // done is only ever a single-cycle pulse
        lsb_done_n   = 1'b0;
        if_result_n  = mc_to_if_result;
        lsb_result_n = mc_to_lsb_result;
`ifdef MC_RR_ARB_EN
        rr_last_n    = rr_last_q;
        if (lsb_to_mc_enable && if_to_mc_enable)
            pick_lsb = (rr_last_q == OWN_IF);
        else
            pick_lsb = lsb_to_mc_enable;
`else
        pick_lsb     = lsb_to_mc_enable;
`endif
        // Read edge k: cnt_q = k-1 on entry (cnt is 0 at the grant edge).
        rd_idx  = cnt_q + 3'd1;
        cap_idx = 2'(rd_idx - 3'd2);
        wr_addr = addr_q + ADDR_WIDTH'(cnt_q);

        case (state_q)
            IDLE: begin
                if (!rob_to_mc_flush && (lsb_to_mc_enable || if_to_mc_enable)) begin
                    owner_n  = pick_lsb ? OWN_LSB : OWN_IF;
                    addr_n   = pick_lsb ? lsb_to_mc_addr : if_to_mc_pc;
                    if (!pick_lsb || (lsb_to_mc_len != 3'd1 && lsb_to_mc_len != 3'd2))
                        len_n = 3'd4;
                    else
                        len_n = lsb_to_mc_len;
                    wdata_n  = lsb_to_mc_data;
                    rbuf_n   = '0;
                    cnt_n    = '0;
                    mem_a_n  = pick_lsb ? lsb_to_mc_addr : if_to_mc_pc;
                    mem_wr_n = 1'b0;
                    state_n  = (pick_lsb && lsb_to_mc_wr) ? WRITE : READ;
`ifdef MC_RR_ARB_EN
                    rr_last_n = pick_lsb ? OWN_LSB : OWN_IF;
`endif
                end
            end
            READ: begin
                if (rob_to_mc_flush) begin
                    state_n  = IDLE;
                    mem_wr_n = 1'b0;
                end else begin
                    cnt_n = rd_idx;
                    if (rd_idx < len_q)
                        mem_a_n = addr_q + ADDR_WIDTH'(rd_idx);
                    // RAM data lags the address by one cycle, so the byte
                    // landing now belongs to the address issued two edges ago.
                    if (rd_idx >= 3'd2)
                        rbuf_n[8*cap_idx +: 8] = mem_din;
                    if (rd_idx == len_q + 3'd1) begin
                        state_n = DONE;
                        if (owner_q == OWN_LSB) begin
                            lsb_done_n   = 1'b1;
                            lsb_result_n = rbuf_n;
                        end else begin
                            if_done_n   = 1'b1;
                            if_result_n = rbuf_n;
                        end
                    end
                end
            end
            WRITE: begin
                // Flush is deliberately ignored: the store is committed.
                if (cnt_q == len_q) begin
                    mem_wr_n   = 1'b0;
                    lsb_done_n = 1'b1;
                    state_n    = DONE;
                end else if (wr_addr >= IO_BASE && io_buffer_full) begin
                    mem_wr_n = 1'b0;
                end else begin
                    mem_a_n    = wr_addr;
                    mem_dout_n = wdata_q[8*cnt_q[1:0] +: 8];
                    mem_wr_n   = 1'b1;
                    cnt_n      = cnt_q + 3'd1;
                end
            end
            DONE: begin
                // Requests are not sampled here so a requester dropping its
                // enable after done is never granted a second time.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            len_q            <= '0;
            cnt_q            <= '0;
            owner_q          <= OWN_IF;
            wdata_q          <= '0;
            rbuf_q           <= '0;
            mem_a            <= '0;
            mem_dout         <= '0;
            mem_wr           <= 1'b0;
            mc_to_if_done    <= 1'b0;
            mc_to_lsb_done   <= 1'b0;
            mc_to_if_result  <= '0;
            mc_to_lsb_result <= '0;
`ifdef MC_RR_ARB_EN
            rr_last_q        <= OWN_LSB;
`endif
        end else if (rdy) begin
            state_q          <= state_n;
            addr_q           <= addr_n;
            len_q            <= len_n;
            cnt_q            <= cnt_n;
            owner_q          <= owner_n;
            wdata_q          <= wdata_n;
            rbuf_q           <= rbuf_n;
            mem_a            <= mem_a_n;
            mem_dout         <= mem_dout_n;
            mem_wr           <= mem_wr_n;
            mc_to_if_done    <= if_done_n;
            mc_to_lsb_done   <= lsb_done_n;
            mc_to_if_result  <= if_result_n;
            mc_to_lsb_result <= lsb_result_n;
`ifdef MC_RR_ARB_EN
            rr_last_q        <= rr_last_n;
`endif
        end
    end

endmodule
